instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 145 ++++++++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-cycle-latency memory reads and presents words over a valid/ready handshake.
// Define FETCH_PREFETCH_EN to replace the single instruction register with a 2-entry prefetch FIFO.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  assign pc       = pc_q;
  assign mem_addr = pc_q;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;

  logic [15:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              pop, push, issue;
  logic [2:0]        committed;

  assign pop         = (count_q != 2'd0) && instr_ready;
  assign push        = inflight_q && !redirect;
  // Credit counts the slot freed by this cycle's pop so a full pipe still issues every cycle.
  assign committed   = 3'(count_q) - 3'(pop) + 3'(inflight_q);
  assign issue       = reset && enable && !redirect && (committed < 3'd2);
  assign mem_rd      = issue;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      inflight_q    <= issue;
      inflight_pc_q <= pc_q;
      if (redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_data_q[wr_ptr_q] <= mem_rdata;
          fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
          wr_ptr_q              <= !wr_ptr_q;
        end
        if (pop) rd_ptr_q <= !rd_ptr_q;
      end
    end
  end

`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE:  if (enable) state_d = REQ;
      REQ:   state_d = WAIT;
      WAIT: begin
        instr_d    = mem_rdata;
        instr_pc_d = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
        state_d    = VALID;
      end
      VALID: if (instr_ready) state_d = enable ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    // A redirect overrides everything, including a word arriving this cycle.
    if (redirect) begin
      pc_d       = redirect_pc;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      state_d    = enable ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_rd      = (state_q == REQ);
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: transaction scoreboard for both builds, cycle reference model for the default build.
module tb_instr_fetch;
  localparam logic [15:0] RST = 16'h0000;

  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = '0, mem_rdata = '0;
  logic [15:0] mem_addr, instr, instr_pc, pc;
  logic        mem_rd, instr_valid;

  int n_checks = 0, n_bad = 0, hs_count = 0;
  logic [15:0] sb_pc = RST;

  // Cycle reference model: issue -> pending -> presented slot
  logic        m_issue = 0, m_pending = 0, m_slot_v = 0;
  logic [15:0] m_pc = RST, m_pend_pc = 0, m_slot_pc = 0, m_slot_data = 0;

  instr_fetch #(.ADDR_W(16), .RESET_PC(RST)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h5103;
    return (a * 16'h2F3B) ^ 16'hC0DE;
  endfunction

  always @(posedge clk) mem_rdata <= mem_rd ? memf(mem_addr) : 16'hDEAD;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_issue = 0; m_pending = 0; m_slot_v = 0; m_pc = RST;
    m_slot_pc = 0; m_slot_data = 0; sb_pc = RST;
  endtask

  task automatic model_edge(input logic en, input logic rdy, input logic rd, input logic [15:0] rpc);
    if (rd) begin
      m_slot_v = 0; m_pending = 0; m_issue = en; m_pc = rpc;
    end else if (m_pending) begin
      m_slot_v = 1; m_slot_pc = m_pend_pc; m_slot_data = memf(m_pend_pc);
      m_pc = m_pend_pc + 16'd1; m_pending = 0;
    end else if (m_issue) begin
      m_pending = 1; m_pend_pc = m_pc; m_issue = 0;
    end else if (m_slot_v) begin
      if (rdy) begin m_slot_v = 0; m_issue = en; end
    end else begin
      m_issue = en;
    end
  endtask

  task automatic check_outputs();
    check_eq("mem_rd", 32'(mem_rd), 32'(m_issue));
    check_eq("instr_valid", 32'(instr_valid), 32'(m_slot_v));
    check_eq("pc", 32'(pc), 32'(m_pc));
    check_eq("mem_addr", 32'(mem_addr), 32'(m_pc));
    if (m_slot_v) begin
      check_eq("instr", 32'(instr), 32'(m_slot_data));
      check_eq("instr_pc", 32'(instr_pc), 32'(m_slot_pc));
    end
  endtask

  // One clock: apply inputs after negedge, score any handshake, update model, check at next negedge.
  task automatic step(input logic en, input logic rdy, input logic rd, input logic [15:0] rpc);
    enable = en; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    if (instr_valid && instr_ready) begin
      check_eq("hs_pc", 32'(instr_pc), 32'(sb_pc));
      check_eq("hs_instr", 32'(instr), 32'(memf(sb_pc)));
      $display("hs #%0d pc=%h instr=%h", hs_count, instr_pc, instr);
      sb_pc = sb_pc + 16'd1;
      hs_count++;
    end
    if (rd) sb_pc = rpc;
    @(posedge clk);
`ifndef FETCH_PREFETCH_EN
    model_edge(en, rdy, rd, rpc);
`endif
    @(negedge clk);
`ifndef FETCH_PREFETCH_EN
    check_outputs();
`endif
  endtask

  task automatic wait_valid(input logic en);
    for (int i = 0; i < 12 && !instr_valid; i++) step(en, 1'b0, 1'b0, 16'h0);
    check_eq("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check_eq({tag, "_pc"}, 32'(pc), 32'(RST));
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'(RST));
    check_eq({tag, "_instr"}, 32'(instr), 32'd0);
    check_eq({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_rd, t_v, hs0;
    // Reset held with enable high
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("rst");

    // Release: first fetch from RESET_PC, valid two cycles after the read
    reset = 1'b1; instr_ready = 1'b1;
    model_reset();
    #1;
    t_rd = -1; t_v = -1;
    for (int c = 0; c < 10; c++) begin
      if (mem_rd && t_rd < 0) t_rd = c;
      if (instr_valid) begin t_v = c; break; end
      step(1'b1, 1'b1, 1'b0, 16'h0);
    end
    check_eq("first_latency", 32'(t_v - t_rd), 32'd2);
    check_eq("first_instr", 32'(instr), 32'h5103);
    check_eq("first_instr_pc", 32'(instr_pc), 32'(RST));
`ifndef FETCH_PREFETCH_EN
    check_eq("first_pc", 32'(pc), 32'(RST + 16'd1));
`endif

    // Stall in VALID for 5 cycles, then exactly one handshake
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_instr_pc", 32'(instr_pc), 32'(sb_pc));
      check_eq("stall_instr", 32'(instr), 32'(memf(sb_pc)));
`ifndef FETCH_PREFETCH_EN
      check_eq("stall_mem_rd", 32'(mem_rd), 32'd0);
`endif
    end
    hs0 = hs_count;
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("stall_one_hs", 32'(hs_count - hs0), 32'd1);

    // Sustained throughput with ready held high
    wait_valid(1'b1);
    hs0 = hs_count;
    repeat (9) step(1'b1, 1'b1, 1'b0, 16'h0);
`ifdef FETCH_PREFETCH_EN
    check_eq("throughput", 32'(hs_count - hs0), 32'd9);
`else
    check_eq("throughput", 32'(hs_count - hs0), 32'd3);
`endif

    // Redirect while a read is in flight
    for (int i = 0; i < 12 && !mem_rd; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    check_eq("req_timeout", 32'(mem_rd), 32'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    wait_valid(1'b1);
    check_eq("redir_instr_pc", 32'(instr_pc), 32'h0040);
    check_eq("redir_instr", 32'(instr), 32'(memf(16'h0040)));

    // Wrap at the top of the address space
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    wait_valid(1'b1);
    check_eq("wrap_instr_pc", 32'(instr_pc), 32'hFFFF);
`ifndef FETCH_PREFETCH_EN
    check_eq("wrap_pc", 32'(pc), 32'h0000);
`endif
    step(1'b1, 1'b1, 1'b0, 16'h0);
    wait_valid(1'b1);
    check_eq("wrap_next_pc", 32'(instr_pc), 32'h0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic en, rdy, rd;
      logic [15:0] rpc;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(en, rdy, rd, rpc);
    end

    // Asynchronous reset while an instruction is presented
    wait_valid(1'b1);
    #2 reset = 1'b0;
    #1 check_reset_state("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst_hold");
    reset = 1'b1; enable = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    #1;
    for (int i = 0; i < 6 && !mem_rd; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    check_eq("refetch_rd", 32'(mem_rd), 32'd1);
    check_eq("refetch_addr", 32'(mem_addr), 32'(RST));
    wait_valid(1'b1);
    check_eq("refetch_instr_pc", 32'(instr_pc), 32'(RST));
    repeat (10) step(1'b1, 1'b1, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
